// File: rtl/dly_tap_sequencer_if.sv
// Command handshake between a calibration/CSR master and the delay-tap sequencer.
interface dly_tap_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_count;

    modport master (output cmd_valid, output cmd_op, output cmd_count, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_count, output cmd_ready);
endinterface

// File: rtl/dly_tap_sequencer.sv
// Turns reset/step-up/step-down commands into spaced idelay_rst/ce/inc pulses
// for the LUT delay-select generator, confirming each step via its done echo.
module dly_tap_sequencer #(
    parameter  int LUTs = 2,
    parameter  int GAP  = 4,
    parameter  int TMO  = 4,
    localparam int TW   = $clog2(LUTs + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dly_tap_sequencer_if.slave   cmd,
    output logic                 idelay_rst,
    output logic                 idelay_ce,
    output logic                 idelay_inc,
    input  logic                 done,
    output logic                 busy,
    output logic [TW-1:0]        tap,
    output logic                 sat,
    output logic                 err
);

    localparam int CNT_MAX = (GAP > TMO) ? GAP : TMO;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [TW-1:0] TAP_MAX  = TW'(LUTs);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_PULSE,
        S_WAIT,
        S_SETTLE
    } state_t;

    state_t          state, state_nx;
    logic            ready_q;
    logic [1:0]      op_q;
    logic [7:0]      remaining;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            step_legal;

    assign accept        = cmd.cmd_valid & ready_q;
    assign cmd.cmd_ready = ready_q;
    assign busy          = ~ready_q;

    // op_q[0] selects direction: 0 = increment, 1 = decrement
    assign step_legal = op_q[0] ? (tap != '0) : (tap < TAP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx == S_IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd.cmd_op == 2'b01)
                        state_nx = S_RST;
                    else if (cmd.cmd_op[1] && (cmd.cmd_count != 8'd0))
                        state_nx = S_PULSE;
                end
            end
            S_RST:   state_nx = S_SETTLE;
            S_PULSE: state_nx = step_legal ? S_WAIT : S_SETTLE;
            S_WAIT: begin
                if (done)
                    state_nx = S_SETTLE;
                else if (cnt == TMO_LAST)
                    state_nx = S_IDLE;
            end
            S_SETTLE: begin
                if (cnt == GAP_LAST)
                    state_nx = (remaining != 8'd0) ? S_PULSE : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        idelay_rst = 1'b0;
        idelay_ce  = 1'b0;
        idelay_inc = 1'b0;
        case (state)
            S_RST:   idelay_rst = 1'b1;
            S_PULSE: begin
                idelay_ce  = step_legal;
                idelay_inc = step_legal & ~op_q[0];
            end
            default: ;
        endcase
    end

    // Cycle counter restarts on every state change, so it measures time in WAIT/SETTLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state_nx != state)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 2'b00;
            remaining <= 8'd0;
            tap       <= '0;
            sat       <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= cmd.cmd_op;
                remaining <= cmd.cmd_count;
                sat       <= 1'b0;
                err       <= 1'b0;
            end
            case (state)
                S_RST: tap <= '0;
                S_PULSE: begin
                    if (!step_legal) begin
                        sat       <= 1'b1;
                        remaining <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        tap       <= op_q[0] ? (tap - 1'b1) : (tap + 1'b1);
                        remaining <= remaining - 1'b1;
                    end else if (cnt == TMO_LAST) begin
                        err       <= 1'b1;
                        remaining <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dly_tap_sequencer.sv
// Scoreboard bench for dly_tap_sequencer: directed commands push expected pulse
// and completion events; a negedge monitor pops and compares them.
module tb_dly_tap_sequencer;

    typedef struct {
        int         kind;   // 0 = ce pulse, 1 = rst pulse, 2 = ready after command
        int         rel;    // cycle index relative to the accept edge
        logic       inc;
        logic [1:0] tap;
        logic       sat;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       idelay_rst, idelay_ce, idelay_inc;
    logic       done;
    logic       busy;
    logic [1:0] tap;
    logic       sat, err;
    logic       done_en;
    logic       inject;

    int   n_checks = 0;
    int   n_errors = 0;
    int   rel      = 0;
    bit   pending  = 0;
    exp_t q[$];

    dly_tap_sequencer_if cmd ();

    dly_tap_sequencer #(.LUTs(2), .GAP(4), .TMO(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .idelay_rst (idelay_rst),
        .idelay_ce  (idelay_ce),
        .idelay_inc (idelay_inc),
        .done       (done),
        .busy       (busy),
        .tap        (tap),
        .sat        (sat),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selector model: registered done echo one cycle after ce, plus stray-done injection
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= (done_en & idelay_ce) | inject;
    end

    task automatic check_val(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_ce(input int r, input logic inc);
        exp_t e;
        e.kind = 0; e.rel = r; e.inc = inc; e.tap = 2'd0; e.sat = 1'b0; e.err = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_rst(input int r);
        exp_t e;
        e.kind = 1; e.rel = r; e.inc = 1'b0; e.tap = 2'd0; e.sat = 1'b0; e.err = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_rdy(input int r, input logic [1:0] t, input logic s, input logic e_);
        exp_t e;
        e.kind = 2; e.rel = r; e.inc = 1'b0; e.tap = t; e.sat = s; e.err = e_;
        q.push_back(e);
    endtask

    // Monitor: compares every pulse and each command completion against the queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pending = 0;
        end else begin
            rel = rel + 1;
            if (idelay_ce || idelay_rst) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_pulse: ce=%0b rst=%0b at rel %0d, none expected",
                             idelay_ce, idelay_rst, rel);
                end else begin
                    e = q.pop_front();
                    if (e.kind != (idelay_rst ? 1 : 0) || e.rel != rel ||
                        (idelay_ce && idelay_rst) || (idelay_ce && idelay_inc != e.inc)) begin
                        n_errors++;
                        $display("FAIL pulse: got ce=%0b rst=%0b inc=%0b rel=%0d expected kind=%0d inc=%0b rel=%0d",
                                 idelay_ce, idelay_rst, idelay_inc, rel, e.kind, e.inc, e.rel);
                    end
                end
            end
            if (pending && cmd.cmd_ready) begin
                pending = 0;
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_ready: rel %0d, none expected", rel);
                end else begin
                    e = q.pop_front();
                    if (e.kind != 2 || e.rel != rel || tap != e.tap || sat != e.sat ||
                        err != e.err || busy != 1'b0) begin
                        n_errors++;
                        $display("FAIL ready: got rel=%0d tap=%0d sat=%0b err=%0b busy=%0b expected kind=%0d rel=%0d tap=%0d sat=%0b err=%0b busy=0",
                                 rel, tap, sat, err, busy, e.kind, e.rel, e.tap, e.sat, e.err);
                    end
                end
            end
            if (cmd.cmd_valid && cmd.cmd_ready) begin
                rel     = 0;
                pending = 1;
            end
        end
    end

    task automatic wait_ready(input string name);
        int i;
        for (i = 0; i < 64; i++) begin
            if (cmd.cmd_ready) break;
            @(posedge clk); #1;
        end
        if (i == 64) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: cmd_ready still 0 after 64 cycles, expected 1", name);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] count);
        wait_ready("pre_issue");
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.cmd_count = count;
        @(posedge clk); #1;
        cmd.cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        done_en       = 1'b1;
        inject        = 1'b0;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'b00;
        cmd.cmd_count = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", int'(cmd.cmd_ready), 1);
        check_val("rst_busy",  int'(busy), 0);
        check_val("rst_tap",   int'(tap), 0);
        check_val("rst_sat",   int'(sat), 0);
        check_val("rst_err",   int'(err), 0);
        check_val("rst_pulses", int'({idelay_ce, idelay_rst, idelay_inc}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single increment
        push_ce(1, 1'b1); push_rdy(7, 2'd1, 1'b0, 1'b0);
        issue(2'b10, 8'd1);
        // single decrement back to 0
        push_ce(1, 1'b0); push_rdy(7, 2'd0, 1'b0, 1'b0);
        issue(2'b11, 8'd1);
        // increment by 5 from 0: two real steps, then clipped
        push_ce(1, 1'b1); push_ce(7, 1'b1); push_rdy(18, 2'd2, 1'b1, 1'b0);
        issue(2'b10, 8'd5);
        repeat (3) @(posedge clk); #1;
        cmd.cmd_valid = 1'b1; cmd.cmd_op = 2'b01; cmd.cmd_count = 8'd0;
        repeat (2) @(posedge clk); #1;
        cmd.cmd_valid = 1'b0;
        wait_ready("inc5");
        // decrement from 2, with a stray done during settle
        push_ce(1, 1'b0); push_rdy(7, 2'd1, 1'b0, 1'b0);
        issue(2'b11, 8'd1);
        repeat (3) @(posedge clk); #1;
        inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        wait_ready("dec_stray");
        // tap reset
        push_rst(1); push_rdy(6, 2'd0, 1'b0, 1'b0);
        issue(2'b01, 8'd0);
        // done never returns: timeout
        wait_ready("rst_cmd");
        done_en = 1'b0;
        push_ce(1, 1'b1); push_rdy(6, 2'd0, 1'b0, 1'b1);
        issue(2'b10, 8'd3);
        wait_ready("timeout");
        done_en = 1'b1;
        // nop clears err
        push_rdy(1, 2'd0, 1'b0, 1'b0);
        issue(2'b00, 8'd7);
        // decrement at 0: clipped, no pulse
        push_rdy(6, 2'd0, 1'b1, 1'b0);
        issue(2'b11, 8'd1);
        // zero-count increment is a nop and clears sat
        push_rdy(1, 2'd0, 1'b0, 1'b0);
        issue(2'b10, 8'd0);
        // async reset during settle of a 3-step increment
        push_ce(1, 1'b1);
        issue(2'b10, 8'd3);
        repeat (3) @(posedge clk); #1;
        check_val("pre_reset_tap", int'(tap), 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ce",    int'(idelay_ce), 0);
        check_val("mid_rst_rst",   int'(idelay_rst), 0);
        check_val("mid_rst_ready", int'(cmd.cmd_ready), 1);
        check_val("mid_rst_tap",   int'(tap), 0);
        check_val("mid_rst_flags", int'({sat, err}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk); #1;
        check_val("post_rst_tap",   int'(tap), 0);
        check_val("post_rst_ready", int'(cmd.cmd_ready), 1);
        check_val("queue_empty",    q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dly_tap_sequencer.md
Name: dly_tap_sequencer

Overview:
Command-driven sequencer that sits directly upstream of the LUT delay-select generator in the Spartan-3 DDR PHY. It turns calibration or CSR commands (reset, step up N taps, step down N taps) into correctly spaced single-cycle idelay_rst / idelay_ce / idelay_inc pulses. It confirms each step against the generator's done echo and keeps a saturating tap count.

Parameters:
LUTs, 2, number of delay taps in the downstream selector; tap range is 0..LUTs
GAP, 4, settle cycles after each pulse before the next pulse or command (>=1)
TMO, 4, cycles to wait for done after a ce pulse before flagging error (>=2)

Ports:
clk  in  1  clock, single domain
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  high when a command can be accepted
cmd_op  in  2  00 nop, 01 reset taps, 10 increment, 11 decrement
cmd_count  in  8  number of steps for inc/dec
idelay_rst  out  1  one-cycle reset pulse to selector
idelay_ce  out  1  one-cycle step enable to selector
idelay_inc  out  1  direction, valid while idelay_ce=1
done  in  1  selector acknowledge, registered, expected one cycle after idelay_ce
busy  out  1  inverse of cmd_ready
tap  out  TW  current tap count, TW = ceil(log2(LUTs+1)), 2 for default
sat  out  1  sticky: a requested step was clipped at 0 or LUTs
err  out  1  sticky: done not seen within TMO cycles

Behaviour:
- Reset (rst_n low, async): state IDLE, cmd_ready=1, idelay_rst=idelay_ce=idelay_inc=0, tap=0, sat=0, err=0, step counter=0.
- Accept: cmd_valid & cmd_ready at rising edge. cmd_op/cmd_count are captured. sat and err clear on every accept.
- States: IDLE, RST, PULSE, WAIT, SETTLE.
- IDLE:
  - op 00, or op 1x with count=0: no-op; stay IDLE, ready stays 1.
  - op 01: go to RST.
  - op 1x with count>0: load remaining=count, go to PULSE.
- RST: idelay_rst=1 for exactly one cycle; tap<=0; then SETTLE.
- PULSE:
  - If the step is legal (inc with tap<LUTs, or dec with tap>0): idelay_ce=1 for one cycle, idelay_inc=op[0]==0; then WAIT.
  - If the step is illegal: no pulse, sat<=1, remaining<=0, go to SETTLE. All clipped steps are dropped.
- WAIT: counts cycles from entry.
  - done=1: tap<=tap±1, remaining<=remaining-1, go to SETTLE.
  - No done after TMO cycles: err<=1, remaining<=0, tap unchanged, go to IDLE. No settle.
- SETTLE: GAP cycles with all pulse outputs 0. Then PULSE if remaining>0, else IDLE.
- Timing: accept at edge k -> idelay_ce high in cycle k+1 -> done sampled in k+2 -> SETTLE k+3..k+2+GAP -> next pulse or cmd_ready=1 in k+3+GAP.
- idelay_ce and idelay_rst are never high together. At most one ce pulse per (2+GAP) cycles.
- A done arriving outside WAIT is ignored.
- cmd_valid while busy is ignored and is not queued.
- cmd_ready is registered and deasserts the cycle after accept.
- rst_n asserted mid-sequence: immediate return to reset values. No further pulses.

Test Plan:
- After reset: op=10, count=1, done echoed 1 cycle after ce, GAP=4 -> exactly one ce pulse with inc=1; tap=1; cmd_ready high 7 cycles after accept; sat=0, err=0.
- Tap=0: op=10, count=5, LUTs=2 -> exactly 2 ce pulses spaced 6 cycles apart; tap=2; sat=1; no third pulse.
- Tap=2: op=11, count=1 -> one ce pulse with inc=0, tap=1. Then op=01 -> single idelay_rst pulse, tap=0, no ce, ready 6 cycles after accept.
- Done tied low: op=10, count=3 -> one ce pulse; err=1 after TMO=4 wait cycles; tap unchanged; ready returns with no further ce. The next accepted command clears err.
- Tap=0: op=11, count=1 -> no ce pulse; sat=1; tap=0. Also op=10 with count=0 -> no pulses, ready stays 1.
- rst_n pulsed low during SETTLE of a 3-step increment -> outputs at reset values immediately; no further ce pulses; tap=0.
